// File: rtl/fpu_vector_sequencer.sv
// fpu_vector_sequencer
//   On-chip vector sequencer for one FPU_top instance. It walks a vector memory of
//   {opcode, round, A, B, expected} entries. For each vector it holds the FPU in
//   reset with stable operands, releases it, and waits for a rising edge on
//   resultReady. It then compares the result and accumulates error and timeout counts.
//
//   Optional feature macro: FPU_SEQ_FAIL_CAPTURE_EN (first-failure index/result capture).
//
//   Ports:
//     clk, reset            clock, asynchronous active-high reset
//     start, stop_on_err    run request (level), stop-at-first-failure (latched at start)
//     busy, done, pass      run status; pass valid with done
//     err_count             saturating count of mismatching vectors
//     timeout_count         saturating count of timed-out vectors
//     fail_index            first failing vector address (feature macro only, else 0)
//     fail_result           first failing result (feature macro only, else 0)
//     vec_addr, vec_data    vector memory address, registered read data
//     fpu_reset             FPU reset (1 = idle)
//     fpu_opcode, fpu_round, fpu_a, fpu_b   FPU operands
//     fpu_ready, fpu_result FPU resultReady / result
module fpu_vector_sequencer #(
  parameter int unsigned N_VECTORS   = 100,
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned HOLD_CYCLES = 2,
  parameter int unsigned TIMEOUT     = 255,
  parameter int unsigned CNT_W       = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop_on_err,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [CNT_W-1:0]  err_count,
  output logic [CNT_W-1:0]  timeout_count,
  output logic [ADDR_W-1:0] fail_index,
  output logic [31:0]       fail_result,
  output logic [ADDR_W-1:0] vec_addr,
  input  logic [101:0]      vec_data,
  output logic              fpu_reset,
  output logic [3:0]        fpu_opcode,
  output logic [1:0]        fpu_round,
  output logic [31:0]       fpu_a,
  output logic [31:0]       fpu_b,
  input  logic              fpu_ready,
  input  logic [31:0]       fpu_result
);

  localparam int unsigned TMR_MAX = (HOLD_CYCLES > TIMEOUT) ? HOLD_CYCLES : TIMEOUT;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

  typedef enum logic [2:0] {IDLE, FETCH, LOAD, HOLD, RUN, CHECK, DONE} state_t;

  state_t           state, nextState;
  logic [TMR_W-1:0] cycCnt;
  logic             readyQ;
  logic             stopQ;
  logic             timedOutQ;
  logic [31:0]      expQ;
  logic [31:0]      resultQ;

  logic readyEdge, holdLast, runLast, lastVec, vecFail;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  // Next-state logic and per-cycle decode
  always_comb begin
    nextState = state;
    readyEdge = fpu_ready & ~readyQ;
    holdLast  = (cycCnt == TMR_W'(HOLD_CYCLES - 1));
    runLast   = (cycCnt == TMR_W'(TIMEOUT - 1));
    lastVec   = (vec_addr == ADDR_W'(N_VECTORS - 1));
    vecFail   = timedOutQ | (resultQ != expQ);
    case (state)
      IDLE:    if (start) nextState = FETCH;
      FETCH:   nextState = LOAD;
      LOAD:    nextState = HOLD;
      HOLD:    if (holdLast) nextState = RUN;
      RUN:     if (readyEdge || runLast) nextState = CHECK;
      CHECK:   nextState = (lastVec || (stopQ && vecFail)) ? DONE : FETCH;
      DONE:    if (!start) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Datapath, status outputs and vector bookkeeping
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      err_count     <= '0;
      timeout_count <= '0;
      vec_addr      <= '0;
      fpu_reset     <= 1'b1;
      fpu_opcode    <= '0;
      fpu_round     <= '0;
      fpu_a         <= '0;
      fpu_b         <= '0;
      cycCnt        <= '0;
      readyQ        <= 1'b1;
      stopQ         <= 1'b0;
      timedOutQ     <= 1'b0;
      expQ          <= '0;
      resultQ       <= '0;
    end else begin
      busy      <= (nextState != IDLE) && (nextState != DONE);
      done      <= (nextState == DONE);
      fpu_reset <= (nextState != RUN);
      // Edge detector is only armed inside RUN, so ready already high on the
      // first RUN cycle never counts as completion.
      readyQ    <= (state == RUN) ? fpu_ready : 1'b1;

      if ((state == nextState) && ((state == HOLD) || (state == RUN)))
        cycCnt <= cycCnt + TMR_W'(1);
      else
        cycCnt <= '0;

      case (state)
        IDLE: begin
          if (start) begin
            err_count     <= '0;
            timeout_count <= '0;
            pass          <= 1'b0;
            vec_addr      <= '0;
            stopQ         <= stop_on_err;
          end
        end
        LOAD: begin
          fpu_opcode <= vec_data[101:98];
          fpu_round  <= vec_data[97:96];
          fpu_a      <= vec_data[95:64];
          fpu_b      <= vec_data[63:32];
          expQ       <= vec_data[31:0];
          timedOutQ  <= 1'b0;
          resultQ    <= '0;
        end
        RUN: begin
          if (readyEdge) begin
            resultQ   <= fpu_result;
            timedOutQ <= 1'b0;
          end else if (runLast) begin
            resultQ   <= '0;
            timedOutQ <= 1'b1;
          end
        end
        CHECK: begin
          if (timedOutQ) begin
            if (timeout_count != '1) timeout_count <= timeout_count + CNT_W'(1);
          end else if (resultQ != expQ) begin
            if (err_count != '1) err_count <= err_count + CNT_W'(1);
          end
          if (nextState == FETCH) vec_addr <= vec_addr + ADDR_W'(1);
          // Counts only grow, so the pre-increment values plus this vector decide pass.
          if (nextState == DONE)
            pass <= (err_count == '0) && (timeout_count == '0) && !vecFail;
        end
        default: ;
      endcase
    end
  end

`ifdef FPU_SEQ_FAIL_CAPTURE_EN
  logic failSeen;

  // First-failure capture, frozen until the next start
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      failSeen    <= 1'b0;
      fail_index  <= '0;
      fail_result <= '0;
    end else if ((state == IDLE) && start) begin
      failSeen    <= 1'b0;
      fail_index  <= '0;
      fail_result <= '0;
    end else if ((state == CHECK) && vecFail && !failSeen) begin
      failSeen    <= 1'b1;
      fail_index  <= vec_addr;
      fail_result <= resultQ;
    end
  end
`else
  assign fail_index  = '0;
  assign fail_result = '0;
`endif

endmodule

// File: tb/tb_fpu_vector_sequencer.sv
// tb_fpu_vector_sequencer
//   Bench for fpu_vector_sequencer: registered-read vector ROM, a behavioural FPU
//   stand-in with per-vector ready behaviour, and a run-level reference model.
module tb_fpu_vector_sequencer;

  localparam int unsigned NV  = 6;
  localparam int unsigned AW  = 4;
  localparam int unsigned HC  = 2;
  localparam int unsigned TO  = 8;
  localparam int unsigned CW  = 2;
  localparam int          SAT = (1 << CW) - 1;

  // Per-vector FPU behaviour
  localparam int M_NORMAL = 0;
  localparam int M_NEVER  = 1;
  localparam int M_STUCK  = 2;

  logic           clk = 1'b0;
  logic           reset, start, stop_on_err;
  logic           busy, done, pass;
  logic [CW-1:0]  err_count, timeout_count;
  logic [AW-1:0]  fail_index, vec_addr;
  logic [31:0]    fail_result;
  logic [101:0]   vec_data;
  logic           fpu_reset, fpu_ready;
  logic [3:0]     fpu_opcode;
  logic [1:0]     fpu_round;
  logic [31:0]    fpu_a, fpu_b, fpu_result;

  always #5 clk = ~clk;

  fpu_vector_sequencer #(
    .N_VECTORS(NV), .ADDR_W(AW), .HOLD_CYCLES(HC), .TIMEOUT(TO), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .stop_on_err(stop_on_err),
    .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .timeout_count(timeout_count),
    .fail_index(fail_index), .fail_result(fail_result),
    .vec_addr(vec_addr), .vec_data(vec_data),
    .fpu_reset(fpu_reset), .fpu_opcode(fpu_opcode), .fpu_round(fpu_round),
    .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_ready(fpu_ready), .fpu_result(fpu_result)
  );

  logic [101:0] rom  [16];
  int           mode [16];
  int           lat  [16];

  int checks   = 0;
  int failures = 0;

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Stand-in FPU function; the MUL 2.0 x 3.0 case returns the real product.
  function automatic logic [31:0] fpuFunc(input logic [3:0] op, input logic [1:0] rnd,
                                          input logic [31:0] a, input logic [31:0] b);
    if (op == 4'd2 && a == 32'h4000_0000 && b == 32'h4040_0000) return 32'h40C0_0000;
    return (a ^ {b[15:0], b[31:16]}) + {26'd0, op, rnd};
  endfunction

  // Registered-read vector memory
  always @(posedge clk) vec_data <= rom[vec_addr];

  // Behavioural FPU: runCyc = number of cycles since release from reset
  int runCyc = 0;
  always @(negedge clk) begin
    if (fpu_reset) runCyc = 0;
    else           runCyc = runCyc + 1;
  end

  always_comb begin
    case (mode[vec_addr])
      M_NEVER: fpu_ready = 1'b0;
      M_STUCK: fpu_ready = (runCyc <= 1) || (runCyc >= 4);
      default: fpu_ready = (runCyc >= lat[vec_addr]);
    endcase
    fpu_result = fpuFunc(fpu_opcode, fpu_round, fpu_a, fpu_b);
  end

  // Monitor: busy cycles and length/address of each FPU release window
  int busyCycles = 0;
  int streak     = 0;
  int runLenQ[$];
  int runAddrQ[$];
  always @(negedge clk) begin
    if (busy) busyCycles++;
    if (!fpu_reset) streak++;
    else if (streak != 0) begin
      runLenQ.push_back(streak);
      runAddrQ.push_back(int'(vec_addr));
      streak = 0;
    end
  end

  task automatic setVec(input int i, input int m, input int l, input bit bad);
    logic [3:0]  op;
    logic [1:0]  rnd;
    logic [31:0] a, b, er;
    op  = 4'($urandom);
    rnd = 2'($urandom);
    a   = $urandom;
    b   = $urandom;
    er  = fpuFunc(op, rnd, a, b);
    if (bad) er = er ^ (32'($urandom) | 32'h1);
    rom[i] = {op, rnd, a, b, er};
    mode[i] = m;
    lat[i]  = l;
  endtask

  task automatic setMulVec(input int i, input int l, input logic [31:0] er);
    rom[i]  = {4'd2, 2'd0, 32'h4000_0000, 32'h4040_0000, er};
    mode[i] = M_NORMAL;
    lat[i]  = l;
  endtask

  task automatic waitDone();
    int n;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!done && n < 4000);
    checkVal("done_reached", 64'(done), 64'(1));
  endtask

  // One full run, checked against a run-level reference derived from the ROM
  task automatic runVectors(input bit stopErr);
    int expErr, expTo, expLast, expBusy, expFailIdx, len, nCmp;
    logic [31:0] expFailRes, res;
    bit seen, isTo, bad;
    int expLens[$];
    expErr = 0; expTo = 0; expLast = 0; expBusy = 0; expFailIdx = 0;
    expFailRes = '0; seen = 0;
    for (int i = 0; i < int'(NV); i++) begin
      isTo = (mode[i] == M_NEVER);
      res  = fpuFunc(rom[i][101:98], rom[i][97:96], rom[i][95:64], rom[i][63:32]);
      bad  = isTo || (res != rom[i][31:0]);
      len  = isTo ? int'(TO) : (mode[i] == M_STUCK ? 4 : lat[i]);
      expLens.push_back(len);
      expBusy += 3 + int'(HC) + len;
      expLast = i;
      if (isTo) expTo++;
      else if (bad) expErr++;
      if (bad && !seen) begin
        seen = 1; expFailIdx = i; expFailRes = isTo ? 32'h0 : res;
      end
      if (bad && stopErr) break;
    end
    if (expErr > SAT) expErr = SAT;
    if (expTo > SAT) expTo = SAT;

    runLenQ.delete(); runAddrQ.delete(); busyCycles = 0;
    stop_on_err = stopErr;
    start = 1'b1;
    waitDone();
    checkVal("err_count",     64'(err_count),     64'(expErr));
    checkVal("timeout_count", 64'(timeout_count), 64'(expTo));
    checkVal("pass",          64'(pass),          64'(expErr == 0 && expTo == 0));
    checkVal("last_addr",     64'(vec_addr),      64'(expLast));
    checkVal("busy_cycles",   64'(busyCycles),    64'(expBusy));
    checkVal("vector_count",  64'(runLenQ.size()), 64'(expLens.size()));
    nCmp = (runLenQ.size() < expLens.size()) ? runLenQ.size() : expLens.size();
    for (int i = 0; i < nCmp; i++) begin
      checkVal($sformatf("run_len[%0d]", i),  64'(runLenQ[i]),  64'(expLens[i]));
      checkVal($sformatf("run_addr[%0d]", i), 64'(runAddrQ[i]), 64'(i));
    end
`ifdef FPU_SEQ_FAIL_CAPTURE_EN
    checkVal("fail_index",  64'(fail_index),  64'(expFailIdx));
    checkVal("fail_result", 64'(fail_result), 64'(expFailRes));
`else
    checkVal("fail_index",  64'(fail_index),  64'(0));
    checkVal("fail_result", 64'(fail_result), 64'(0));
`endif
    // start held high through DONE must not relaunch
    busyCycles = 0;
    repeat (4) @(posedge clk);
    #1;
    checkVal("held_start_busy", 64'(busyCycles), 64'(0));
    checkVal("held_start_done", 64'(done),       64'(1));
    start = 1'b0;
    @(posedge clk); #1;
    checkVal("done_cleared",   64'(done),      64'(0));
    checkVal("count_persists", 64'(err_count), 64'(expErr));
  endtask

  initial begin
    int n;
    for (int i = 0; i < 16; i++) begin
      rom[i] = '0; mode[i] = M_NORMAL; lat[i] = 3;
    end
    reset = 1'b1; start = 1'b0; stop_on_err = 1'b0;
    #1;
    checkVal("rst_fpu_reset", 64'(fpu_reset), 64'(1));
    checkVal("rst_status",    64'({busy, done, pass}), 64'(0));
    checkVal("rst_counts",    64'({err_count, timeout_count}), 64'(0));
    checkVal("rst_operands",  64'({fpu_opcode, fpu_round, vec_addr}) | 64'(fpu_a) | 64'(fpu_b), 64'(0));
    checkVal("rst_fail",      64'(fail_index) | 64'(fail_result), 64'(0));
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;

    // All correct, L=3
    for (int i = 0; i < int'(NV); i++) setVec(i, M_NORMAL, 3, 0);
    setMulVec(0, 3, 32'h40C0_0000);
    runVectors(0);

    // Vector 2 corrupted, without and with stop-on-error
    setMulVec(2, 3, 32'h40C0_0001);
    runVectors(0);
    runVectors(1);

    // Timeout, stuck-high ready, and ready edge exactly at the timeout limit
    for (int i = 0; i < int'(NV); i++) setVec(i, M_NORMAL, 3, 0);
    mode[1] = M_NEVER;
    mode[3] = M_STUCK;
    lat[4]  = int'(TO);
    lat[5]  = 2;
    runVectors(0);

    // Everything failing: counters saturate
    for (int i = 0; i < int'(NV); i++) setVec(i, (i < 4) ? M_NEVER : M_NORMAL, 4, 1);
    runVectors(0);
    for (int i = 0; i < int'(NV); i++) setVec(i, M_NORMAL, 2, 1);
    runVectors(0);

    // Randomized runs
    for (int r = 0; r < 25; r++) begin
      for (int i = 0; i < int'(NV); i++) begin
        int m;
        m = $urandom_range(0, 9);
        setVec(i, (m == 7) ? M_NEVER : (m == 8) ? M_STUCK : M_NORMAL,
               $urandom_range(2, TO), ($urandom_range(0, 3) == 0));
      end
      runVectors(1'($urandom_range(0, 1)));
    end

    // Reset in the middle of a RUN window after an error was counted
    for (int i = 0; i < int'(NV); i++) setVec(i, M_NORMAL, 6, (i == 0));
    stop_on_err = 1'b0;
    start = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!(vec_addr == AW'(3) && !fpu_reset) && n < 2000);
    checkVal("mid_run_reached", 64'(!fpu_reset), 64'(1));
    checkVal("mid_run_err",     64'(err_count),  64'(1));
    #2 reset = 1'b1;
    #1;
    checkVal("midrst_fpu_reset", 64'(fpu_reset), 64'(1));
    checkVal("midrst_busy",      64'(busy),       64'(0));
    checkVal("midrst_counts",    64'({err_count, timeout_count}), 64'(0));
    checkVal("midrst_addr_ops",  64'({vec_addr, fpu_opcode}) | 64'(fpu_a), 64'(0));
    start = 1'b0;
    #3 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkVal("post_rst_idle", 64'({busy, done, fpu_reset}), 64'(1));

    // Normal run after the reset
    for (int i = 0; i < int'(NV); i++) setVec(i, M_NORMAL, 5, 0);
    runVectors(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
